// File: rtl/nios_system_pio_edge_in_pkg.sv
// Shared constants for the edge-capturing input PIO: register offsets and edge encodings.
package nios_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_pio_edge_in_if.sv
// Avalon-MM slave bus of the input PIO; readdata is combinational, zero wait states.
interface nios_system_pio_edge_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/nios_system_pio_edge_in_sync_edge.sv
// Input synchroniser plus per-bit edge detector; edge_pulse is valid SYNC_STAGES cycles after sampling
// and is held off for SYNC_STAGES+1 cycles after reset so static inputs do not look like edges.
module nios_system_pio_sync_edge
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_data,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] WARM_DONE = CW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [CW-1:0]                     r_warm;
  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  w_raw_edge;
  logic                              w_warm_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
      r_prev <= r_sync[SYNC_STAGES-1];
      if (r_warm != WARM_DONE) begin
        r_warm <= r_warm + 1'b1;
      end
    end
  end

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_warm_done = (r_warm == WARM_DONE);

  always_comb begin
    w_raw_edge = w_sync & ~r_prev;
    if (EDGE_TYPE == EDGE_FALL) begin
      w_raw_edge = ~w_sync & r_prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      w_raw_edge = w_sync ^ r_prev;
    end
  end

  assign sync_data  = w_sync;
  assign edge_pulse = w_raw_edge & {WIDTH{w_warm_done}};

endmodule

// File: rtl/nios_system_pio_edge_in.sv
// Avalon-MM input PIO: DATA/IRQ_MASK/EDGE_CAPTURE registers, 0-cycle reads, no wait states;
// irq is registered one cycle behind the capture and mask registers.
module nios_system_pio_edge_in
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  nios_system_pio_edge_in_if.slave    bus,
  input  logic [WIDTH-1:0]            in_port,
  output logic                        irq
);

  logic [WIDTH-1:0] w_sync_data;
  logic [WIDTH-1:0] w_edge_pulse;
  logic [WIDTH-1:0] w_clear_mask;
  logic             w_wr;
  logic [31:0]      w_readdata;
  logic             w_unused;

  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic             r_irq;

  nios_system_pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .sync_data (w_sync_data),
    .edge_pulse(w_edge_pulse)
  );

  assign w_wr         = bus.chipselect & ~bus.write_n;
  assign w_clear_mask = (w_wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_unused     = &{1'b0, bus.writedata};

  // A new edge is ORed in after the clear, so an edge coinciding with a clear survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask     <= '0;
      r_edge_capture <= '0;
      r_irq          <= 1'b0;
    end else begin
      if (w_wr && bus.address == ADDR_MASK) begin
        r_irq_mask <= bus.writedata[WIDTH-1:0];
      end
      r_edge_capture <= (r_edge_capture & ~w_clear_mask) | w_edge_pulse;
      r_irq          <= |(r_edge_capture & r_irq_mask);
    end
  end

  always_comb begin
    w_readdata = '0;
    case (bus.address)
      ADDR_DATA: w_readdata[WIDTH-1:0] = w_sync_data;
      ADDR_MASK: w_readdata[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE: w_readdata[WIDTH-1:0] = r_edge_capture;
      default:   w_readdata = '0;
    endcase
  end

  assign bus.readdata = w_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_nios_system_pio_edge_in.sv
// Directed bench: a 16-bit rising-edge instance and an 8-bit any-edge instance share clock and reset.
module tb_nios_system_pio_edge_in;
  import nios_system_pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_port = 16'h0000;
  logic [7:0]  in8 = 8'h00;
  logic        irq;
  logic        irq8;
  int          checks = 0;
  int          failures = 0;

  nios_system_pio_edge_in_if bus();
  nios_system_pio_edge_in_if bus8();

  always #5 clk = ~clk;

  nios_system_pio_edge_in #(.WIDTH(16), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(in_port), .irq(irq)
  );

  nios_system_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8), .in_port(in8), .irq(irq8)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit w8, input logic [1:0] a, input logic [31:0] d);
    if (w8) begin
      bus8.address = a; bus8.writedata = d; bus8.chipselect = 1'b1; bus8.write_n = 1'b0;
    end else begin
      bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus8.chipselect = 1'b0; bus8.write_n = 1'b1;
  endtask

  task automatic rd(input bit w8, input logic [1:0] a, output logic [31:0] d);
    if (w8) begin
      bus8.address = a; bus8.chipselect = 1'b1; bus8.write_n = 1'b1;
    end else begin
      bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    end
    #1;
    d = w8 ? bus8.readdata : bus.readdata;
    bus.chipselect = 1'b0; bus8.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    in_port = 16'hFFFF;
    tick(3);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rd(0, ADDR_DATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", d); end
    rd(0, ADDR_MASK, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_mask: got %h expected 00000000", d); end
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_edge: got %h expected 00000000", d); end
    reset_n = 1'b1;
    tick(1);
    rd(0, ADDR_DATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL data_1edge: got %h expected 00000000", d); end
    tick(1);
    rd(0, ADDR_DATA, d);
    checks++; if (d !== 32'h0000FFFF) begin failures++; $display("FAIL data_2edge: got %h expected 0000ffff", d); end
    tick(4);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL warmup_edge: got %h expected 00000000", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL warmup_irq: got %b expected 0", irq); end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    in_port = 16'h0000;
    tick(4);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL fall_ignored: got %h expected 00000000", d); end
    wr(0, ADDR_MASK, 32'h1);
    in_port = 16'h0001;
    tick(2);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL edge_early: got %h expected 00000000", d); end
    tick(1);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL edge_set: got %h expected 00000001", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early: got %b expected 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise: got %b expected 1", irq); end
    wr(0, ADDR_EDGE, 32'h1);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL edge_clear: got %h expected 00000000", d); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_lag: got %b expected 1", irq); end
    tick(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_drop: got %b expected 0", irq); end
  endtask

  task automatic test_clear_collide();
    logic [31:0] d;
    in_port = 16'h0009;
    tick(4);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL bit3_set: got %h expected 00000008", d); end
    in_port = 16'h0001;
    tick(4);
    in_port = 16'h0009;
    tick(2);
    wr(0, ADDR_EDGE, 32'h8);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL edge_wins: got %h expected 00000008", d); end
    wr(0, ADDR_EDGE, 32'h8);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL bit3_clear: got %h expected 00000000", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL unmasked_irq: got %b expected 0", irq); end
  endtask

  task automatic test_mask_all();
    logic [31:0] d;
    wr(0, ADDR_MASK, 32'h0);
    in_port = 16'h0000;
    tick(4);
    in_port = 16'hFFFF;
    tick(4);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h0000FFFF) begin failures++; $display("FAIL all_edges: got %h expected 0000ffff", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask0_irq: got %b expected 0", irq); end
    wr(0, ADDR_MASK, 32'hFFFF8000);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq_1st: got %b expected 0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL mask_irq_2nd: got %b expected 1", irq); end
    rd(0, ADDR_MASK, d);
    checks++; if (d !== 32'h00008000) begin failures++; $display("FAIL mask_read: got %h expected 00008000", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    rd(0, 2'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL off1_read: got %h expected 00000000", d); end
    wr(0, ADDR_DATA, 32'h00001234);
    wr(0, 2'd1, 32'hFFFFFFFF);
    rd(0, ADDR_DATA, d);
    checks++; if (d !== 32'h0000FFFF) begin failures++; $display("FAIL data_ro: got %h expected 0000ffff", d); end
    rd(0, 2'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL off1_ro: got %h expected 00000000", d); end
    rd(0, ADDR_MASK, d);
    checks++; if (d !== 32'h00008000) begin failures++; $display("FAIL mask_kept: got %h expected 00008000", d); end
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h0000FFFF) begin failures++; $display("FAIL edge_kept: got %h expected 0000ffff", d); end
    wr(0, ADDR_EDGE, 32'hFFFFFFFF);
    rd(0, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL clear_all: got %h expected 00000000", d); end
    tick(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_clear: got %b expected 0", irq); end
  endtask

  task automatic test_width8_any();
    logic [31:0] d;
    wr(1, ADDR_MASK, 32'hFFFFFFFF);
    rd(1, ADDR_MASK, d);
    checks++; if (d !== 32'h000000FF) begin failures++; $display("FAIL w8_mask: got %h expected 000000ff", d); end
    in8 = 8'hFF;
    tick(4);
    rd(1, ADDR_DATA, d);
    checks++; if (d !== 32'h000000FF) begin failures++; $display("FAIL w8_data: got %h expected 000000ff", d); end
    rd(1, ADDR_EDGE, d);
    checks++; if (d !== 32'h000000FF) begin failures++; $display("FAIL w8_edge: got %h expected 000000ff", d); end
    checks++; if (irq8 !== 1'b1) begin failures++; $display("FAIL w8_irq: got %b expected 1", irq8); end
    wr(1, ADDR_EDGE, 32'hFF);
    tick(1);
    checks++; if (irq8 !== 1'b0) begin failures++; $display("FAIL w8_irq_clr: got %b expected 0", irq8); end
    in8 = 8'hDF;
    tick(4);
    in8 = 8'hFF;
    tick(4);
    rd(1, ADDR_EDGE, d);
    checks++; if (d !== 32'h00000020) begin failures++; $display("FAIL any_bit5: got %h expected 00000020", d); end
    wr(1, ADDR_EDGE, 32'h20);
    rd(1, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL any_clear: got %h expected 00000000", d); end
    in8 = 8'hDF;
    tick(4);
    rd(1, ADDR_EDGE, d);
    checks++; if (d !== 32'h00000020) begin failures++; $display("FAIL any_recap: got %h expected 00000020", d); end
    checks++; if (irq8 !== 1'b1) begin failures++; $display("FAIL any_irq: got %b expected 1", irq8); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    in8 = 8'hFF;
    tick(1);
    reset_n = 1'b0;
    #1;
    checks++; if (irq8 !== 1'b0) begin failures++; $display("FAIL arst_irq8: got %b expected 0", irq8); end
    rd(1, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL arst_edge8: got %h expected 00000000", d); end
    rd(1, ADDR_MASK, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL arst_mask8: got %h expected 00000000", d); end
    rd(1, ADDR_DATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL arst_data8: got %h expected 00000000", d); end
    rd(0, ADDR_MASK, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL arst_mask: got %h expected 00000000", d); end
    tick(2);
    reset_n = 1'b1;
    tick(5);
    rd(1, ADDR_EDGE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rewarm_edge8: got %h expected 00000000", d); end
    rd(1, ADDR_DATA, d);
    checks++; if (d !== 32'h000000FF) begin failures++; $display("FAIL rewarm_data8: got %h expected 000000ff", d); end
  endtask

  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
    bus8.address = 2'd0; bus8.chipselect = 1'b0; bus8.write_n = 1'b1; bus8.writedata = 32'h0;
    test_reset();
    test_rise_irq();
    test_clear_collide();
    test_mask_all();
    test_regs();
    test_width8_any();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
